// File: rtl/fifo_pkt_rx_pkg.sv
// Shared definitions for the FIFO packet receiver: parser states, sync marker
// and the header field layout that the MCU firmware uses too.
package fifo_pkt_rx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_CMD    = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_LEN_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte offsets within a frame, counted from the sync byte.
  localparam int HDR_OFS_SYNC   = 0;
  localparam int HDR_OFS_CMD    = 1;
  localparam int HDR_OFS_LEN_LO = 2;
  localparam int HDR_OFS_LEN_HI = 3;
  localparam int HDR_BYTES      = 4;
  localparam int CSUM_BYTES     = 1;

endpackage

// File: rtl/fifo_pop_ctl.sv
// FIFO pop pacing: one fifo_oe pulse per byte, then POP_GAP idle cycles so the
// FIFO's edge detect and read pointer settle before the next sample.
module fifo_pop_ctl #(
  parameter int POP_GAP = 4
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic       accept,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_do,
  output logic       fifo_oe,
  output logic       byte_vld,
  output logic [7:0] byte_data
);
  localparam int GW = $clog2(POP_GAP + 1);

  logic [GW-1:0] gap_q, gap_d;
  logic          fire;

  always_comb begin
    fire  = !sys_rst && accept && !fifo_empty && (gap_q == '0);
    gap_d = gap_q;
    if (fire) begin
      gap_d = GW'(POP_GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  assign fifo_oe   = fire;
  assign byte_vld  = fire;
  assign byte_data = fire ? fifo_do : 8'h00;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/fifo_pkt_rx.sv
// Framed packet receiver: sync, cmd, len_lo, len_hi, payload, checksum.
// Optional inter-byte timeout is built in when FIFO_PKT_TIMEOUT_EN is defined.
module fifo_pkt_rx
  import fifo_pkt_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int          AW        = 9,
  parameter int          MAX_LEN   = 512,
  parameter int          POP_GAP   = 4
`ifdef FIFO_PKT_TIMEOUT_EN
  , parameter int        TOUT_CYC  = 50000
`endif
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          fifo_empty,
  input  logic [7:0]    fifo_do,
  output logic          fifo_oe,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_di,
  output logic          pkt_ready,
  output logic [7:0]    pkt_cmd,
  output logic [15:0]   pkt_len,
  input  logic          pkt_ack,
  output logic          err_csum,
  output logic          err_len,
  input  logic          err_clr
);

  rx_state_e   state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  sum_q, sum_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pkt_ready_q, pkt_ready_d;
  logic [7:0]  pkt_cmd_q, pkt_cmd_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic        err_csum_q, err_csum_d;
  logic        err_len_q, err_len_d;
  logic [15:0] len_new;

  logic        accept;
  logic        byte_vld;
  logic [7:0]  byte_data;
  logic        tout_expired;

  assign accept = (state_q != ST_DONE) && !tout_expired;

  fifo_pop_ctl #(
    .POP_GAP (POP_GAP)
  ) u_pop_ctl (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .accept     (accept),
    .fifo_empty (fifo_empty),
    .fifo_do    (fifo_do),
    .fifo_oe    (fifo_oe),
    .byte_vld   (byte_vld),
    .byte_data  (byte_data)
  );

`ifdef FIFO_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TOUT_CYC + 1);

  logic [TW-1:0] tout_q, tout_d;
  logic          tout_active;

  assign tout_active  = (state_q != ST_HUNT) && (state_q != ST_DONE);
  assign tout_expired = tout_active && (tout_q == '0);

  always_comb begin
    tout_d = tout_q;
    if (!tout_active || byte_vld) begin
      tout_d = TW'(TOUT_CYC);
    end else if (tout_q != '0) begin
      tout_d = tout_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      tout_q <= TW'(TOUT_CYC);
    end else begin
      tout_q <= tout_d;
    end
  end
`else
  assign tout_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    sum_d       = sum_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pkt_ready_d = pkt_ready_q;
    pkt_cmd_d   = pkt_cmd_q;
    pkt_len_d   = pkt_len_q;
    // A fresh error in the same cycle as err_clr overrides the clear below.
    err_csum_d  = err_clr ? 1'b0 : err_csum_q;
    err_len_d   = err_clr ? 1'b0 : err_len_q;
    len_new     = {byte_data, len_q[7:0]};
    buf_we      = 1'b0;
    buf_addr    = '0;
    buf_di      = 8'h00;

    if (tout_expired) begin
      state_d   = ST_HUNT;
      err_len_d = 1'b1;
    end else if (byte_vld) begin
      unique case (state_q)
        ST_HUNT: begin
          if (byte_data == SYNC_BYTE) state_d = ST_CMD;
        end
        ST_CMD: begin
          cmd_d   = byte_data;
          sum_d   = byte_data;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d   = {8'h00, byte_data};
          sum_d   = sum_q + byte_data;
          state_d = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_d = len_new;
          sum_d = sum_q + byte_data;
          if (len_new > 16'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else if (len_new == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            cnt_d   = 16'd0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          buf_we   = 1'b1;
          buf_addr = cnt_q[AW-1:0];
          buf_di   = byte_data;
          sum_d    = sum_q + byte_data;
          cnt_d    = cnt_q + 16'd1;
          if (cnt_q == len_q - 16'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (byte_data == ~sum_q) begin
            pkt_cmd_d   = cmd_q;
            pkt_len_d   = len_q;
            pkt_ready_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    // DONE never fetches, so the ack path cannot collide with byte handling.
    if ((state_q == ST_DONE) && pkt_ack) begin
      pkt_ready_d = 1'b0;
      state_d     = ST_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= ST_HUNT;
      cmd_q       <= 8'h00;
      sum_q       <= 8'h00;
      len_q       <= 16'h0000;
      cnt_q       <= 16'h0000;
      pkt_ready_q <= 1'b0;
      pkt_cmd_q   <= 8'h00;
      pkt_len_q   <= 16'h0000;
      err_csum_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      pkt_ready_q <= pkt_ready_d;
      pkt_cmd_q   <= pkt_cmd_d;
      pkt_len_q   <= pkt_len_d;
      err_csum_q  <= err_csum_d;
      err_len_q   <= err_len_d;
    end
  end

  assign pkt_ready = pkt_ready_q;
  assign pkt_cmd   = pkt_cmd_q;
  assign pkt_len   = pkt_len_q;
  assign err_csum  = err_csum_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_fifo_pkt_rx.sv
// Self-checking bench for fifo_pkt_rx: frame-level reference model checked
// every cycle, plus directed packets with literal expectations.
module tb_fifo_pkt_rx;
  import fifo_pkt_rx_pkg::*;

  localparam int AW      = 9;
  localparam int MAX_LEN = 512;
  localparam int POP_GAP = 4;
`ifdef FIFO_PKT_TIMEOUT_EN
  localparam int TOUT_CYC = 50000;
`endif

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [7:0]    fifo_do = 8'h00;
  logic          fifo_oe;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_di;
  logic          pkt_ready;
  logic [7:0]    pkt_cmd;
  logic [15:0]   pkt_len;
  logic          pkt_ack = 1'b0;
  logic          err_csum;
  logic          err_len;
  logic          err_clr = 1'b0;

  fifo_pkt_rx #(
    .AW      (AW),
    .MAX_LEN (MAX_LEN),
    .POP_GAP (POP_GAP)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .fifo_empty (fifo_empty),
    .fifo_do    (fifo_do),
    .fifo_oe    (fifo_oe),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_di     (buf_di),
    .pkt_ready  (pkt_ready),
    .pkt_cmd    (pkt_cmd),
    .pkt_len    (pkt_len),
    .pkt_ack    (pkt_ack),
    .err_csum   (err_csum),
    .err_len    (err_len),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: array with pointers; bench pushes, FIFO process pops.
  logic [7:0] fmem [0:4095];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int pop_req = 0;

  always @(posedge clk) begin
    #1;
    rd_ptr     = pop_req;
    fifo_empty = (rd_ptr == wr_ptr);
    fifo_do    = (rd_ptr == wr_ptr) ? 8'h00 : fmem[rd_ptr];
  end

  task automatic push_bytes(input logic [7:0] bs[$]);
    foreach (bs[k]) begin
      fmem[wr_ptr] = bs[k];
      wr_ptr++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state (frame level).
  logic [7:0] mem [0:(1<<AW)-1];
  int         n_oe = 0;
  int         n_we = 0;
  bit         m_in_frame = 0;
  logic [7:0] m_frame[$];
  logic       m_ready = 0;
  logic [7:0] m_cmd = 0;
  logic [15:0] m_len = 0;
  logic       m_err_csum = 0;
  logic       m_err_len = 0;
  int         m_since = POP_GAP + 1;
`ifdef FIFO_PKT_TIMEOUT_EN
  int         m_idle = 0;
`endif

  always @(negedge clk) begin
    logic          exp_oe, exp_we, tout_now, set_csum, set_len;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_di, b, s;
    int            i, flen;

    tout_now = 1'b0;
`ifdef FIFO_PKT_TIMEOUT_EN
    tout_now = m_in_frame && (m_idle == TOUT_CYC + 1);
`endif
    exp_oe = !sys_rst && !fifo_empty && !m_ready && (m_since > POP_GAP) && !tout_now;

    check("pkt_ready", pkt_ready, m_ready);
    check("pkt_cmd",   pkt_cmd,   m_cmd);
    check("pkt_len",   pkt_len,   m_len);
    check("err_csum",  err_csum,  m_err_csum);
    check("err_len",   err_len,   m_err_len);
    check("fifo_oe",   fifo_oe,   exp_oe);

    exp_we = 0; exp_addr = '0; exp_di = 8'h00; set_csum = 0; set_len = 0;

    if (sys_rst) begin
      m_in_frame = 0; m_frame.delete();
      m_ready = 0; m_cmd = 0; m_len = 0; m_err_csum = 0; m_err_len = 0;
    end else begin
      if (tout_now) begin
        set_len = 1; m_in_frame = 0;
      end
      if (fifo_oe) begin
        b = fifo_do;
        if (!m_in_frame) begin
          if (b == SYNC_BYTE_DEF) begin
            m_in_frame = 1;
            m_frame.delete();
            m_frame.push_back(b);
          end
        end else begin
          m_frame.push_back(b);
          i = m_frame.size() - 1;
          flen = 0;
          if (i >= HDR_OFS_LEN_HI)
            flen = int'({m_frame[HDR_OFS_LEN_HI], m_frame[HDR_OFS_LEN_LO]});
          if (i == HDR_OFS_LEN_HI && flen > MAX_LEN) begin
            set_len = 1; m_in_frame = 0;
          end else if (i >= HDR_BYTES && i < HDR_BYTES + flen) begin
            exp_we = 1; exp_addr = AW'(i - HDR_BYTES); exp_di = b;
          end else if (i >= HDR_BYTES && i == HDR_BYTES + flen + CSUM_BYTES - 1) begin
            s = 8'h00;
            for (int k = HDR_OFS_SYNC + 1; k < i; k++) s = s + m_frame[k];
            if (b == ~s) begin
              m_ready = 1; m_cmd = m_frame[HDR_OFS_CMD]; m_len = 16'(flen);
            end else begin
              set_csum = 1;
            end
            m_in_frame = 0;
          end
        end
      end else if (m_ready && pkt_ack) begin
        m_ready = 0;
      end
      m_err_csum = set_csum ? 1'b1 : (err_clr ? 1'b0 : m_err_csum);
      m_err_len  = set_len  ? 1'b1 : (err_clr ? 1'b0 : m_err_len);
    end

    check("buf_we", buf_we, exp_we);
    if (exp_we) begin
      check("buf_addr", buf_addr, exp_addr);
      check("buf_di",   buf_di,   exp_di);
    end
    if (buf_we) begin
      mem[buf_addr] = buf_di;
      n_we++;
    end
    if (fifo_oe) begin
      pop_req++;
      n_oe++;
      m_since = 1;
    end else if (sys_rst) begin
      m_since = POP_GAP + 1;
    end else if (m_since < 1000) begin
      m_since++;
    end
`ifdef FIFO_PKT_TIMEOUT_EN
    if (fifo_oe || sys_rst) m_idle = 0;
    else if (m_idle < TOUT_CYC + 10) m_idle++;
`endif
  end

  task automatic wait_ready(input string tag, input int budget);
    int k = 0;
    while (!pkt_ready && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_ready_seen"}, pkt_ready, 1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (rd_ptr != wr_ptr && k < budget) begin
      tick();
      k++;
    end
    repeat (10) tick();
    check({tag, "_drained"}, rd_ptr, wr_ptr);
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
    tick();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    int base_oe, base_we;

    repeat (3) tick();
    check("rst_fifo_oe",   fifo_oe,   0);
    check("rst_buf_we",    buf_we,    0);
    check("rst_pkt_ready", pkt_ready, 0);
    check("rst_err_csum",  err_csum,  0);
    check("rst_err_len",   err_len,   0);
    sys_rst = 1'b0;

    // Valid packet with two payload bytes.
    base_oe = n_oe; base_we = n_we;
    q = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h11, 8'h22, 8'hC9};
    push_bytes(q);
    wait_ready("p1", 200);
    check("p1_cmd",    pkt_cmd, 8'h01);
    check("p1_len",    pkt_len, 16'd2);
    check("p1_oe_cnt", n_oe - base_oe, 7);
    check("p1_we_cnt", n_we - base_we, 2);
    check("p1_mem0",   mem[0], 8'h11);
    check("p1_mem1",   mem[1], 8'h22);
    check("p1_errs",   {err_csum, err_len}, 0);

    // Hold while ready, then ack releases the second packet.
    q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h33, 8'hC9};
    push_bytes(q);
    base_oe = n_oe;
    repeat (100) tick();
    check("hold_no_oe",    n_oe - base_oe, 0);
    check("hold_ready",    pkt_ready, 1);
    ack();
    wait_ready("p2", 200);
    check("p2_cmd",  pkt_cmd, 8'h02);
    check("p2_len",  pkt_len, 16'd1);
    check("p2_mem0", mem[0], 8'h33);
    check("p2_mem1", mem[1], 8'h22);
    ack();

    // Garbage before sync, zero-length packet.
    base_oe = n_oe; base_we = n_we;
    q = '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'h00, 8'hF8};
    push_bytes(q);
    wait_ready("p3", 200);
    check("p3_cmd",    pkt_cmd, 8'h07);
    check("p3_len",    pkt_len, 16'd0);
    check("p3_oe_cnt", n_oe - base_oe, 7);
    check("p3_no_we",  n_we - base_we, 0);
    ack();

    // Bad checksum.
    q = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h55, 8'h00};
    push_bytes(q);
    wait_drain("p4", 200);
    check("p4_err_csum", err_csum, 1);
    check("p4_ready",    pkt_ready, 0);
    clear_errs();
    check("p4_clr", err_csum, 0);

    // Over-length, then a valid packet proves the parser is hunting again.
    base_we = n_we;
    q = '{8'hA5, 8'h03, 8'h01, 8'h02};
    push_bytes(q);
    wait_drain("p5", 200);
    check("p5_err_len", err_len, 1);
    check("p5_no_we",   n_we - base_we, 0);
    q = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'hFB};
    push_bytes(q);
    wait_ready("p6", 200);
    check("p6_cmd", pkt_cmd, 8'h04);
    ack();
    clear_errs();

    // Reset mid-DATA after the first payload byte.
    base_we = n_we;
    q = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h11};
    push_bytes(q);
    begin
      int k = 0;
      while (n_we == base_we && k < 200) begin tick(); k++; end
    end
    check("p7_first_we", n_we - base_we, 1);
    sys_rst = 1'b1;
    tick();
    check("p7_rst_oe",    fifo_oe,   0);
    check("p7_rst_we",    buf_we,    0);
    check("p7_rst_addr",  buf_addr,  0);
    check("p7_rst_di",    buf_di,    0);
    check("p7_rst_ready", pkt_ready, 0);
    check("p7_rst_cmd",   pkt_cmd,   0);
    check("p7_rst_len",   pkt_len,   0);
    check("p7_rst_errs",  {err_csum, err_len}, 0);
    sys_rst = 1'b0;
    base_we = n_we;
    q = '{8'h22, 8'hA5, 8'h05, 8'h00, 8'h00, 8'hFA};
    push_bytes(q);
    wait_ready("p7", 200);
    check("p7_cmd",   pkt_cmd, 8'h05);
    check("p7_no_we", n_we - base_we, 0);
    ack();

`ifdef FIFO_PKT_TIMEOUT_EN
    base_we = n_we;
    q = '{8'hA5, 8'h06, 8'h02, 8'h00, 8'h44};
    push_bytes(q);
    repeat (TOUT_CYC + 60) tick();
    check("to_err_len", err_len, 1);
    check("to_ready",   pkt_ready, 0);
    check("to_we_cnt",  n_we - base_we, 1);
    q = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'hF7};
    push_bytes(q);
    wait_ready("to_next", 200);
    check("to_next_cmd", pkt_cmd, 8'h08);
    ack();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
